// File: rtl/ram_pkg.sv
// ram_pkg: FSM encoding and legal parameter values shared by dual_port_be_ram
package ram_pkg;
  typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_READY} state_e;
  localparam int RD_LAT_MIN   = 1;
  localparam int RD_LAT_MAX   = 2;
  localparam int WR_FIRST_OFF = 0;
  localparam int WR_FIRST_ON  = 1;
endpackage

// File: rtl/ram_be_core.sv
// ram_be_core: word array with byte-masked write and one registered, holding read port
module ram_be_core #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     wa,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DATA_W-1:0]     wd,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     ra,
  output logic [DATA_W-1:0]     rd
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_d, rd_q;
  always_comb rd_d = re ? mem[ra] : rd_q;
  always_ff @(posedge clk) begin
    if (!rst) rd_q <= '0;
    else rd_q <= rd_d;
    for (int k = 0; k < DATA_W/8; k++)
      if (we && be[k]) mem[wa][8*k +: 8] <= wd[8*k +: 8];
  end
  assign rd = rd_q;
endmodule

// File: rtl/dual_port_be_ram.sv
// dual_port_be_ram: byte-enable RAM with self-clearing init, collision policy and 1/2-cycle read latency
module dual_port_be_ram
  import ram_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int DEPTH    = 16,
  parameter int RD_LAT   = 1,
  parameter int WR_FIRST = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w,
  input  logic [ADDR_W-1:0]     write_add,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic [DATA_W-1:0]     d,
  input  logic                  r,
  input  logic [ADDR_W-1:0]     read_add,
  output logic [DATA_W-1:0]     out,
  output logic                  rd_valid,
  output logic                  init_busy,
  output logic                  addr_err
);
  localparam int BE_W = DATA_W/8;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

  if (DATA_W % 8 != 0 || DATA_W < 8 || DEPTH < 2 || DEPTH > (1 << ADDR_W) ||
      RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX ||
      (WR_FIRST != WR_FIRST_OFF && WR_FIRST != WR_FIRST_ON)) begin : g_bad_param
    $error("dual_port_be_ram: illegal parameter value");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready, w_oor, r_oor, w_ok, r_acc, r_ok, coll;
  logic              v1_q, v1_d, oor1_q, oor1_d, coll1_q, coll1_d, err_q, err_d;
  logic [DATA_W-1:0] wd1_q, wd1_d, core_rd, mask, data1, core_wd;
  logic [BE_W-1:0]   be1_q, be1_d, core_be;
  logic [ADDR_W-1:0] core_wa;
  logic              core_we;

  always_ff @(posedge clk)
    if (!rst) state_q <= ST_RESET;
    else state_q <= state_d;

  always_comb
    state_d = state_q == ST_RESET ? ST_CLEAR :
              state_q == ST_CLEAR ? (cnt_q == LAST ? ST_READY : ST_CLEAR) : ST_READY;

  // The write port doubles as the zeroing engine while clearing
  always_comb begin
    ready     = state_q == ST_READY;
    init_busy = !ready;
    cnt_d     = state_q == ST_CLEAR ? cnt_q + 1'b1 : '0;
    core_we   = state_q == ST_CLEAR || w_ok;
    core_wa   = ready ? write_add : cnt_q;
    core_be   = ready ? wr_be : '1;
    core_wd   = ready ? d : '0;
  end

  always_comb begin
    w_oor   = {1'b0, write_add} >= DEPTH_L;
    r_oor   = {1'b0, read_add} >= DEPTH_L;
    w_ok    = ready && w && !w_oor;
    r_acc   = ready && r;
    r_ok    = r_acc && !r_oor;
    coll    = WR_FIRST == WR_FIRST_ON && w_ok && r_ok && write_add == read_add;
    v1_d    = r_acc;
    oor1_d  = r_acc ? r_oor : oor1_q;
    coll1_d = r_acc ? coll : coll1_q;
    wd1_d   = r_acc ? d : wd1_q;
    be1_d   = r_acc ? wr_be : be1_q;
    err_d   = ready && ((w && w_oor) || (r && r_oor));
  end

  // Core returns the pre-write word; write-first collisions overlay the captured write lanes
  always_comb begin
    mask = '0;
    for (int k = 0; k < BE_W; k++) mask[8*k +: 8] = {8{be1_q[k]}};
    data1 = oor1_q ? '0 : coll1_q ? (core_rd & ~mask) | (wd1_q & mask) : core_rd;
  end

  always_ff @(posedge clk)
    if (!rst) begin
      cnt_q   <= '0;
      v1_q    <= 1'b0;
      oor1_q  <= 1'b0;
      coll1_q <= 1'b0;
      wd1_q   <= '0;
      be1_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      v1_q    <= v1_d;
      oor1_q  <= oor1_d;
      coll1_q <= coll1_d;
      wd1_q   <= wd1_d;
      be1_q   <= be1_d;
      err_q   <= err_d;
    end

  assign addr_err = err_q;

  ram_be_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_core (
    .clk(clk), .rst(rst), .we(core_we), .wa(core_wa), .be(core_be), .wd(core_wd),
    .re(r_ok), .ra(read_add), .rd(core_rd)
  );

  if (RD_LAT == 1) begin : g_lat1
    assign out      = data1;
    assign rd_valid = v1_q;
  end else begin : g_lat2
    logic [DATA_W-1:0] out2_q, out2_d;
    logic              v2_q;
    always_comb out2_d = v1_q ? data1 : out2_q;
    always_ff @(posedge clk)
      if (!rst) begin
        out2_q <= '0;
        v2_q   <= 1'b0;
      end else begin
        out2_q <= out2_d;
        v2_q   <= v1_q;
      end
    assign out      = out2_q;
    assign rd_valid = v2_q;
  end
endmodule

// File: tb/tb_dual_port_be_ram.sv
// tb_dual_port_be_ram: A = 16 words, RD_LAT 1, read-first; B = 12 words, RD_LAT 2, write-first; shared stimulus
module tb_dual_port_be_ram;
  localparam int DW = 32;
  localparam int AW = 4;
  logic clk = 0, rst = 0, w = 0, r = 0;
  logic [AW-1:0] write_add = '0, read_add = '0;
  logic [3:0] wr_be = '0;
  logic [DW-1:0] d = '0;
  logic [DW-1:0] out_a, out_b, ea, eb;
  logic v_a, v_b, busy_a, busy_b, err_a, err_b;
  logic [DW-1:0] mem_a [16], mem_b [16];
  logic [DW-1:0] qa [$], qb [$];
  int checks = 0, failures = 0;
  int na, nb;

  always #5 clk = ~clk;

  dual_port_be_ram #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .RD_LAT(1), .WR_FIRST(0)) u_a (
    .clk(clk), .rst(rst), .w(w), .write_add(write_add), .wr_be(wr_be), .d(d), .r(r),
    .read_add(read_add), .out(out_a), .rd_valid(v_a), .init_busy(busy_a), .addr_err(err_a));
  dual_port_be_ram #(.DATA_W(32), .ADDR_W(4), .DEPTH(12), .RD_LAT(2), .WR_FIRST(1)) u_b (
    .clk(clk), .rst(rst), .w(w), .write_add(write_add), .wr_be(wr_be), .d(d), .r(r),
    .read_add(read_add), .out(out_b), .rd_valid(v_b), .init_busy(busy_b), .addr_err(err_b));

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw, input logic [3:0] be);
    logic [DW-1:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = be[k] ? nw[8*k +: 8] : old[8*k +: 8];
    return m;
  endfunction

  task automatic step(input logic wi, input int wa, input logic [3:0] bi, input logic [DW-1:0] di, input logic ri, input int ra);
    w = wi; write_add = AW'(wa); wr_be = bi; d = di; r = ri; read_add = AW'(ra);
    if (ri) begin
      qa.push_back(mem_a[ra]);
      qb.push_back(ra >= 12 ? '0 : (wi && wa == ra) ? merge(mem_b[ra], di, bi) : mem_b[ra]);
    end
    if (wi) begin
      mem_a[wa] = merge(mem_a[wa], di, bi);
      if (wa < 12) mem_b[wa] = merge(mem_b[wa], di, bi);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 4'h0, '0, 0, 0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
  endtask

  task automatic count_busy(output int ca, output int cb);
    ca = 0; cb = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (busy_a) ca++;
      if (busy_b) cb++;
      if (!busy_a && !busy_b) break;
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (v_a) begin
      checks++;
      if (qa.size() == 0) begin failures++; $display("FAIL rd_a_unexpected out=%h", out_a); end
      else begin ea = qa.pop_front(); if (out_a !== ea) begin failures++; $display("FAIL rd_a_data got=%h exp=%h", out_a, ea); end end
    end
    if (v_b) begin
      checks++;
      if (qb.size() == 0) begin failures++; $display("FAIL rd_b_unexpected out=%h", out_b); end
      else begin eb = qb.pop_front(); if (out_b !== eb) begin failures++; $display("FAIL rd_b_data got=%h exp=%h", out_b, eb); end end
    end
  end

  task automatic test_reset();
    rst = 0; r = 1; w = 1; write_add = 4'd2; read_add = 4'd2; d = 32'hFFFF_FFFF; wr_be = 4'hF;
    repeat (3) @(negedge clk);
    checks++; if ({out_a, out_b} !== '0) begin failures++; $display("FAIL reset_out got=%h/%h exp=0", out_a, out_b); end
    checks++; if ({v_a, v_b, err_a, err_b} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {v_a, v_b, err_a, err_b}); end
    checks++; if ({busy_a, busy_b} !== 2'b11) begin failures++; $display("FAIL reset_busy got=%b exp=11", {busy_a, busy_b}); end
    r = 0; w = 0;
  endtask

  task automatic test_init();
    rst = 1;
    count_busy(na, nb);
    checks++; if (na != 16) begin failures++; $display("FAIL init_busy_a cycles=%0d exp=16", na); end
    checks++; if (nb != 12) begin failures++; $display("FAIL init_busy_b cycles=%0d exp=12", nb); end
    clear_model();
    for (int i = 0; i < 16; i++) step(0, 0, 4'h0, '0, 1, i);
    idle(3);
    checks++; if (qa.size() + qb.size() != 0) begin failures++; $display("FAIL init_drain left=%0d exp=0", qa.size() + qb.size()); end
  endtask

  task automatic test_byte_enable();
    step(1, 3, 4'hF, 32'hAABBCCDD, 0, 0);
    step(1, 3, 4'h5, 32'h11223344, 0, 0);
    step(1, 3, 4'h0, 32'hDEADBEEF, 0, 0);
    step(0, 0, 4'h0, '0, 1, 3);
    checks++; if (!v_a || out_a !== 32'hAA22CC44) begin failures++; $display("FAIL be_a got=%h v=%b exp=aa22cc44", out_a, v_a); end
    idle(1);
    checks++; if (!v_b || out_b !== 32'hAA22CC44) begin failures++; $display("FAIL be_b got=%h v=%b exp=aa22cc44", out_b, v_b); end
    idle(2);
  endtask

  task automatic test_collision();
    step(1, 5, 4'hF, 32'hFFFFFFFF, 0, 0);
    step(1, 5, 4'hF, 32'h12345678, 1, 5);
    checks++; if (out_a !== 32'hFFFFFFFF) begin failures++; $display("FAIL coll_read_first got=%h exp=ffffffff", out_a); end
    idle(1);
    checks++; if (out_b !== 32'h12345678) begin failures++; $display("FAIL coll_write_first got=%h exp=12345678", out_b); end
    step(1, 6, 4'h3, 32'hABCDEF01, 1, 6);
    step(0, 0, 4'h0, '0, 1, 5);
    idle(3);
    checks++; if (qa.size() + qb.size() != 0) begin failures++; $display("FAIL coll_drain left=%0d exp=0", qa.size() + qb.size()); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) step(1, i, 4'hF, 32'h0000A000 + i, 0, 0);
    idle(1);
    step(0, 0, 4'h0, '0, 1, 0);
    checks++; if ({v_a, v_b} !== 2'b10) begin failures++; $display("FAIL lat_c0 got=%b exp=10", {v_a, v_b}); end
    step(0, 0, 4'h0, '0, 1, 1);
    checks++; if ({v_a, v_b} !== 2'b11) begin failures++; $display("FAIL lat_c1 got=%b exp=11", {v_a, v_b}); end
    step(0, 0, 4'h0, '0, 1, 2);
    checks++; if ({v_a, v_b} !== 2'b11) begin failures++; $display("FAIL lat_c2 got=%b exp=11", {v_a, v_b}); end
    idle(1);
    checks++; if ({v_a, v_b} !== 2'b01) begin failures++; $display("FAIL lat_c3 got=%b exp=01", {v_a, v_b}); end
    idle(1);
    checks++; if ({v_a, v_b} !== 2'b00) begin failures++; $display("FAIL lat_c4 got=%b exp=00", {v_a, v_b}); end
    checks++; if (out_a !== 32'h0000A002 || out_b !== 32'h0000A002) begin failures++; $display("FAIL out_hold got=%h/%h exp=0000a002", out_a, out_b); end
  endtask

  task automatic test_addr_err();
    step(1, 14, 4'hF, 32'h5555AAAA, 0, 0);
    checks++; if ({err_a, err_b} !== 2'b01) begin failures++; $display("FAIL err_wr got=%b exp=01", {err_a, err_b}); end
    idle(1);
    checks++; if (err_b !== 1'b0) begin failures++; $display("FAIL err_wr_pulse got=%b exp=0", err_b); end
    step(0, 0, 4'h0, '0, 1, 14);
    checks++; if ({err_a, err_b} !== 2'b01) begin failures++; $display("FAIL err_rd got=%b exp=01", {err_a, err_b}); end
    idle(1);
    checks++; if (err_b !== 1'b0 || v_b !== 1'b1 || out_b !== '0) begin failures++; $display("FAIL err_rd_data err=%b v=%b out=%h exp 0/1/0", err_b, v_b, out_b); end
    step(1, 13, 4'hF, 32'h00000001, 1, 15);
    checks++; if (err_b !== 1'b1) begin failures++; $display("FAIL err_both got=%b exp=1", err_b); end
    idle(1);
    checks++; if (err_b !== 1'b0) begin failures++; $display("FAIL err_both_once got=%b exp=0", err_b); end
    idle(2);
    checks++; if (qa.size() + qb.size() != 0) begin failures++; $display("FAIL err_drain left=%0d exp=0", qa.size() + qb.size()); end
  endtask

  task automatic test_reset_restart();
    step(0, 0, 4'h0, '0, 1, 2);
    void'(qb.pop_back());  // B's read is still in its pipeline when reset hits
    r = 0; rst = 0;
    @(negedge clk);
    checks++; if ({v_a, v_b, busy_a, busy_b} !== 4'b0011 || out_a !== '0) begin failures++; $display("FAIL inflight_drop flags=%b out=%h exp=0011/0", {v_a, v_b, busy_a, busy_b}, out_a); end
    rst = 1;
    repeat (5) @(negedge clk);
    r = 1; read_add = 4'd1;
    @(negedge clk);
    r = 0; rst = 0;
    @(negedge clk);
    rst = 1;
    count_busy(na, nb);
    checks++; if (na != 16 || nb != 12) begin failures++; $display("FAIL restart_busy cycles=%0d/%0d exp=16/12", na, nb); end
    clear_model();
    step(0, 0, 4'h0, '0, 1, 3);
    checks++; if (!v_a || out_a !== '0) begin failures++; $display("FAIL restart_cleared got=%h v=%b exp=0", out_a, v_a); end
    idle(3);
    checks++; if (qa.size() + qb.size() != 0) begin failures++; $display("FAIL restart_drain left=%0d exp=0", qa.size() + qb.size()); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_init();
    test_byte_enable();
    test_collision();
    test_back_to_back();
    test_addr_err();
    test_reset_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dual_port_be_ram.md
DUAL_PORT_BE_RAM -- requirements
Module: dual_port_be_ram

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 4, address width.
REQ-003 Parameter DEPTH, default 16, word count; SHALL satisfy 2 <= DEPTH <= 2**ADDR_W.
REQ-004 Parameter RD_LAT, default 1, read latency in cycles; legal values 1 or 2.
REQ-005 Parameter WR_FIRST, default 0; 1 = write-first collision mode, 0 = read-first.
REQ-006 clk  in  1  sole clock; all logic on its rising edge.
REQ-007 rst  in  1  reset, synchronous, active-low.
REQ-008 w  in  1  write request.
REQ-009 write_add  in  ADDR_W  write address.
REQ-010 wr_be  in  DATA_W/8  byte-lane write enable; bit k covers d[8k+7:8k].
REQ-011 d  in  DATA_W  write data.
REQ-012 r  in  1  read request.
REQ-013 read_add  in  ADDR_W  read address.
REQ-014 out  out  DATA_W  registered read data.
REQ-015 rd_valid  out  1  high for exactly one cycle when out carries the data for a read.
REQ-016 init_busy  out  1  high while memory initialisation is in progress.
REQ-017 addr_err  out  1  one-cycle pulse when an accepted r or w addresses a location >= DEPTH.

Function
REQ-018 The FSM SHALL have states RESET, CLEAR, READY: RESET while rst=0; RESET->CLEAR on the first edge with rst=1; CLEAR->READY after clearing address DEPTH-1; any state->RESET when rst=0.
REQ-019 In CLEAR, the block SHALL zero one word per cycle, ascending from address 0, so init_busy falls exactly DEPTH cycles after rst deasserts.
REQ-020 r and w SHALL be ignored (no memory change, no rd_valid, no addr_err) outside READY.
REQ-021 In READY, a write SHALL update only the byte lanes with wr_be=1; w=1 with wr_be=0 SHALL leave memory unchanged.
REQ-022 A read accepted at edge N SHALL present data on out with rd_valid=1 after edge N+RD_LAT-1 (RD_LAT=1: same edge; RD_LAT=2: one edge later).
REQ-023 out SHALL hold its last value when no read completes; rd_valid SHALL be 0 in that cycle.
REQ-024 Back-to-back reads SHALL be accepted every cycle at full throughput for both RD_LAT values.
REQ-025 For a same-cycle r and w to one address, the block SHALL return the merged new word (enabled lanes from d, others old) if WR_FIRST=1, else the pre-write word.
REQ-026 A write with write_add >= DEPTH SHALL be dropped and SHALL pulse addr_err.
REQ-027 A read with read_add >= DEPTH SHALL return all-zero data with rd_valid=1 at normal latency and SHALL pulse addr_err.
REQ-028 If both ports are out of range in one cycle, addr_err SHALL pulse once.
REQ-029 Reads in flight when rst falls SHALL be discarded; no rd_valid SHALL appear until a new read in READY.

Reset
REQ-030 While rst=0: out=0, rd_valid=0, addr_err=0, init_busy=1, the pipeline stage is cleared, and the clear pointer is 0.
REQ-031 Reasserting rst during CLEAR SHALL restart clearing from address 0 after release.
REQ-032 Memory contents SHALL be guaranteed zero only after init_busy falls.

Structure
REQ-033 FSM state encoding and the RD_LAT and WR_FIRST legal-value constants SHALL reside in shared package ram_pkg.
REQ-034 Storage SHALL be one sub-module, ram_be_core (array, byte-masked write, single registered read), with FSM, collision logic and latency pipeline in the top level.
REQ-035 Illegal parameter values SHALL be rejected at elaboration.

Verification
REQ-036 Reset with DEPTH=16, release rst -> init_busy=1 for exactly 16 cycles; then reads of addresses 0..15 return 0x00000000.
REQ-037 Write 0xAABBCCDD to address 3 with wr_be=4'b1111, then 0x11223344 with wr_be=4'b0101 -> read of address 3 returns 0xAA22CC44.
REQ-038 Same-cycle write of 0x12345678 (wr_be=4'b1111) and read to address 5, which holds 0xFFFFFFFF -> WR_FIRST=0 returns 0xFFFFFFFF; WR_FIRST=1 returns 0x12345678.
REQ-039 RD_LAT=2, reads of addresses 0,1,2 on consecutive cycles -> rd_valid high for 3 consecutive cycles, starting one cycle later than with RD_LAT=1, data in order.
REQ-040 DEPTH=12, ADDR_W=4, write to address 14 then read address 14 -> memory unchanged, read returns 0, addr_err pulses once per request.
REQ-041 rst=0 for one cycle midway through CLEAR, with a read issued just before -> no rd_valid; init_busy stays high for 16 cycles after the re-release.
